// File: rtl/ysyx_23060191_exu_pkg.sv
// Shared definitions for the sequential execute unit: widths, opcode and
// operand-routing encodings, FSM states and the multiply/divide op descriptor.
package ysyx_23060191_exu_pkg;

  localparam int EXU_XLEN  = 32;
  localparam int EXU_OPT_W = 5;
  localparam int EXU_SEL_W = 3;

  localparam logic [EXU_OPT_W-1:0] EXU_ADD    = 5'd0;
  localparam logic [EXU_OPT_W-1:0] EXU_SUB    = 5'd1;
  localparam logic [EXU_OPT_W-1:0] EXU_AND    = 5'd2;
  localparam logic [EXU_OPT_W-1:0] EXU_OR     = 5'd3;
  localparam logic [EXU_OPT_W-1:0] EXU_XOR    = 5'd4;
  localparam logic [EXU_OPT_W-1:0] EXU_SLL    = 5'd5;
  localparam logic [EXU_OPT_W-1:0] EXU_SRL    = 5'd6;
  localparam logic [EXU_OPT_W-1:0] EXU_SRA    = 5'd7;
  localparam logic [EXU_OPT_W-1:0] EXU_SLT    = 5'd8;
  localparam logic [EXU_OPT_W-1:0] EXU_SLTU   = 5'd9;
  localparam logic [EXU_OPT_W-1:0] EXU_MUL    = 5'd10;
  localparam logic [EXU_OPT_W-1:0] EXU_MULH   = 5'd11;
  localparam logic [EXU_OPT_W-1:0] EXU_MULHSU = 5'd12;
  localparam logic [EXU_OPT_W-1:0] EXU_MULHU  = 5'd13;
  localparam logic [EXU_OPT_W-1:0] EXU_DIV    = 5'd14;
  localparam logic [EXU_OPT_W-1:0] EXU_DIVU   = 5'd15;
  localparam logic [EXU_OPT_W-1:0] EXU_REM    = 5'd16;
  localparam logic [EXU_OPT_W-1:0] EXU_REMU   = 5'd17;

  localparam logic [EXU_SEL_W-1:0] SEL_PC_ADD_4    = 3'd1;
  localparam logic [EXU_SEL_W-1:0] SEL_PC_ADD_IMM  = 3'd2;
  localparam logic [EXU_SEL_W-1:0] SEL_RS1_ADD_IMM = 3'd3;
  localparam logic [EXU_SEL_W-1:0] SEL_RS1_ADD_RS2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exu_state_e;

  // upper selects the high product half for multiplies, the remainder for divides
  typedef struct packed {
    logic div;
    logic a_signed;
    logic b_signed;
    logic upper;
  } mdu_op_t;

  function automatic mdu_op_t decode_mdu(input logic [EXU_OPT_W-1:0] op);
    mdu_op_t d;
    d = '0;
    case (op)
      EXU_MULH:   d = '{div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b1};
      EXU_MULHSU: d = '{div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, upper: 1'b1};
      EXU_MULHU:  d = '{div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b1};
      EXU_DIV:    d = '{div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b0};
      EXU_DIVU:   d = '{div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b0};
      EXU_REM:    d = '{div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b1};
      EXU_REMU:   d = '{div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b1};
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ysyx_23060191_mdu_iter.sv
// Iterative multiply/divide: shift-add multiplier and restoring divider sharing
// one 2*XLEN accumulator; works on magnitudes and fixes signs on the last step.
module ysyx_23060191_mdu_iter
  import ysyx_23060191_exu_pkg::*;
#(
  parameter int XLEN = EXU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN-1:0]   opnd, a_mag, b_mag, quo, rem;
  logic [XLEN:0]     sum, diff;
  logic [CW-1:0]     cnt;
  logic              a_neg, b_neg, neg_lo, neg_hi;
  mdu_op_t           op_q;

  assign a_neg = op.a_signed & a[XLEN-1];
  assign b_neg = op.b_signed & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: add multiplicand into the high half, shift right.
  // Divide: shift left, trial-subtract divisor, restore when negative.
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (!op_q.div)
      acc_nx = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nx = {acc[2*XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod = neg_lo ? -acc_nx : acc_nx;
    quo  = neg_lo ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem  = neg_hi ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    if (op_q.div)
      res = op_q.upper ? rem : quo;
    else
      res = op_q.upper ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      op_q   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      acc    <= {{XLEN{1'b0}}, (op.div ? a_mag : b_mag)};
      opnd   <= op.div ? b_mag : a_mag;
      cnt    <= CW'(XLEN);
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= op.div ? a_neg : (a_neg ^ b_neg);
      op_q   <= op;
    end else if (cnt != '0) begin
      acc <= acc_nx;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060191_exu_seq.sv
// Sequential execute unit: operand select, single-cycle ALU, iterative M-ext
// ops via the MDU, and valid/ready handshakes towards IDU and WBU.
module ysyx_23060191_exu_seq
  import ysyx_23060191_exu_pkg::*;
#(
  parameter int XLEN  = EXU_XLEN,
  parameter int OPT_W = EXU_OPT_W,
  parameter int SEL_W = EXU_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  data_Rs1,
  input  logic [XLEN-1:0]  data_Rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic [OPT_W-1:0] exu_opt_code,
  input  logic [SEL_W-1:0] exu_sel_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  exu_res,
  output exu_state_e       dbg_state
);

  // Handshake: a request transfers when in_valid&in_ready (in_ready depends on
  // state only); a result transfers when out_valid&out_ready; flush overrides both.

  localparam int SHW = $clog2(XLEN);

  exu_state_e               state, state_nx;
  logic [EXU_OPT_W-1:0]     opt;
  logic [EXU_SEL_W-1:0]     sel;
  logic [XLEN-1:0]          in1, in2, alu_res, mdu_res, res_q, min_val;
  logic [SHW-1:0]           shamt;
  logic                     accept, is_div, signed_div, div_zero, div_ovf, iter, mdu_last;

  assign opt     = EXU_OPT_W'(exu_opt_code);
  assign sel     = EXU_SEL_W'(exu_sel_code);
  assign min_val = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    in1 = '0;
    in2 = '0;
    case (sel)
      SEL_PC_ADD_4:    begin in1 = pc;       in2 = XLEN'(4); end
      SEL_PC_ADD_IMM:  begin in1 = pc;       in2 = imm;      end
      SEL_RS1_ADD_IMM: begin in1 = data_Rs1; in2 = imm;      end
      SEL_RS1_ADD_RS2: begin in1 = data_Rs1; in2 = data_Rs2; end
      default:         begin in1 = '0;       in2 = '0;       end
    endcase
  end

  // Divide-by-zero and signed overflow finish on the single-cycle path.
  assign shamt      = in2[SHW-1:0];
  assign is_div     = (opt == EXU_DIV) || (opt == EXU_DIVU) || (opt == EXU_REM) || (opt == EXU_REMU);
  assign signed_div = (opt == EXU_DIV) || (opt == EXU_REM);
  assign div_zero   = (in2 == '0);
  assign div_ovf    = signed_div && (in1 == min_val) && (in2 == '1);
  assign iter       = (opt >= EXU_MUL) && (opt <= EXU_REMU) && !(is_div && (div_zero || div_ovf));

  always_comb begin
    alu_res = '0;
    case (opt)
      EXU_ADD:             alu_res = in1 + in2;
      EXU_SUB:             alu_res = in1 - in2;
      EXU_AND:             alu_res = in1 & in2;
      EXU_OR:              alu_res = in1 | in2;
      EXU_XOR:             alu_res = in1 ^ in2;
      EXU_SLL:             alu_res = in1 << shamt;
      EXU_SRL:             alu_res = in1 >> shamt;
      EXU_SRA:             alu_res = $signed(in1) >>> shamt;
      EXU_SLT:             alu_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      EXU_SLTU:            alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
      EXU_DIV, EXU_DIVU:   alu_res = div_zero ? '1 : min_val;
      EXU_REM, EXU_REMU:   alu_res = div_zero ? in1 : '0;
      default:             alu_res = '0;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign exu_res   = res_q;
  assign dbg_state = state;
  assign accept    = in_valid && in_ready && !flush;

  ysyx_23060191_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (accept && iter),
    .op    (decode_mdu(opt)),
    .a     (in1),
    .b     (in2),
    .last  (mdu_last),
    .res   (mdu_res)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mdu_last) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept && !iter)
        res_q <= alu_res;
      else if (state == ST_BUSY && mdu_last && !flush)
        res_q <= mdu_res;
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_exu_seq.sv
// Self-checking bench for the sequential EXU: directed and random ops with a
// reference model, latency/backpressure, flush and mid-operation reset.
module tb_ysyx_23060191_exu_seq;
  import ysyx_23060191_exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0, data_Rs1 = '0, data_Rs2 = '0, imm = '0;
  logic [4:0]  exu_opt_code = '0;
  logic [2:0]  exu_sel_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] exu_res;
  exu_state_e  dbg_state;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  ysyx_23060191_exu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .data_Rs1(data_Rs1), .data_Rs2(data_Rs2), .imm(imm),
    .exu_opt_code(exu_opt_code), .exu_sel_code(exu_sel_code),
    .out_valid(out_valid), .out_ready(out_ready), .exu_res(exu_res), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return {31'd0, $signed(a) < $signed(b)};
      5'd9:  return {31'd0, a < b};
      5'd10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'd11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      5'd12: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      5'd13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd10 || op > 5'd17) return 1;
    if (op >= 5'd14 && b == 0) return 1;
    if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drive one request from a negedge; it is accepted at the following posedge.
  task automatic send(input logic [4:0] op, input logic [2:0] sel,
                      input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] iv);
    logic [31:0] a, b;
    int wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    case (sel)
      3'd1:    begin a = pcv; b = 32'd4; end
      3'd2:    begin a = pcv; b = iv;    end
      3'd3:    begin a = r1;  b = iv;    end
      3'd4:    begin a = r1;  b = r2;    end
      default: begin a = 0;   b = 0;     end
    endcase
    exp_q.push_back(model(op, a, b));
    lat_q.push_back(model_lat(op, a, b));
    exu_opt_code = op; exu_sel_code = sel;
    pc = pcv; data_Rs1 = r1; data_Rs2 = r2; imm = iv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc = $urandom; data_Rs1 = $urandom; data_Rs2 = $urandom; imm = $urandom;
    exu_opt_code = 5'($urandom_range(0, 31)); exu_sel_code = 3'($urandom_range(0, 7));
  endtask

  // Wait for the result, optionally stall the consumer, then take and compare.
  task automatic take(input int hold);
    int lat = 0;
    bit got = 0;
    logic [31:0] exp;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin got = 1; break; end
    end
    if (!got) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    check("latency", 32'(lat), 32'(lat_q.pop_front()));
    exp = exp_q[0];
    for (int h = 0; h < hold; h++) begin
      check("hold_res", exu_res, exp);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    check("res", exu_res, exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit saw;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_exu_res", exu_res, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(EXU_ADD, SEL_PC_ADD_4, 32'h8000_0000, 0, 0, 0);             take(0);
    send(EXU_SRA, SEL_RS1_ADD_RS2, 0, 32'h8000_0000, 32'h21, 0);     take(0);
    send(EXU_MULH, SEL_RS1_ADD_RS2, 0, 32'hFFFF_FFFF, 32'd2, 0);     take(0);
    send(EXU_MULHU, SEL_RS1_ADD_RS2, 0, 32'hFFFF_FFFF, 32'd2, 0);    take(0);
    send(EXU_DIV, SEL_RS1_ADD_RS2, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0); take(0);
    send(EXU_REM, SEL_RS1_ADD_RS2, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0); take(0);
    send(EXU_DIVU, SEL_RS1_ADD_RS2, 0, 32'd7, 32'd0, 0);             take(0);
    send(EXU_REMU, SEL_RS1_ADD_RS2, 0, 32'd7, 32'd0, 0);             take(0);
    send(EXU_REM, SEL_RS1_ADD_RS2, 0, 32'hFFFF_FFF9, 32'd2, 0);      take(0);
    send(EXU_DIV, SEL_RS1_ADD_RS2, 0, 32'hFFFF_FFF9, 32'd2, 0);      take(0);
    send(EXU_MUL, SEL_RS1_ADD_IMM, 0, 32'h1234_5678, 0, 32'h9ABC_DEF0); take(0);
    send(EXU_DIVU, SEL_RS1_ADD_RS2, 0, 32'd100, 32'd7, 0);           take(10);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r2;
      r2 = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      send(5'($urandom_range(0, 19)), 3'($urandom_range(0, 5)), $urandom, $urandom, r2, $urandom);
      take($urandom_range(0, 2));
    end

    // flush during the iterative phase
    send(EXU_MUL, SEL_RS1_ADD_RS2, 0, 32'd3, 32'd5, 0);
    void'(exp_q.pop_back()); void'(lat_q.pop_back());
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw = 1;
      @(negedge clk);
    end
    check("flush_no_valid", 32'(saw), 32'd0);

    // flush with a simultaneous take, then flush with a simultaneous request
    send(EXU_ADD, SEL_RS1_ADD_RS2, 0, 32'd1, 32'd2, 0);
    void'(exp_q.pop_back()); void'(lat_q.pop_back());
    @(negedge clk);
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    exu_opt_code = EXU_ADD; exu_sel_code = SEL_RS1_ADD_RS2; in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept_ignored_valid", 32'(out_valid), 32'd0);
    check("flush_accept_ignored_ready", 32'(in_ready), 32'd1);

    // asynchronous reset in the middle of a multiply
    send(EXU_MULHU, SEL_RS1_ADD_RS2, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_exu_res", exu_res, 32'd0);
    exp_q.delete(); lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(EXU_SUB, SEL_PC_ADD_IMM, 32'd10, 0, 0, 32'd20);  take(0);
    send(EXU_SLT, SEL_RS1_ADD_RS2, 0, 32'hFFFF_FFFF, 32'd1, 0); take(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_exu_seq.md
# ysyx_23060191_exu_seq

Sequential, parametrised execute unit: successor to the combinational add-only EXU. Selects ALU operands from pc/rs1/rs2/imm, executes RV-style integer ALU ops in one cycle and M-extension multiply/divide iteratively. It decouples IDU and WBU through valid/ready handshakes on both sides. It sits between the decode stage and write-back in the multi-cycle NPC.

## Interface
- XLEN, 32: datapath width (power of two, ≥8)
- OPT_W, 5: exu_opt_code width
- SEL_W, 3: exu_sel_code width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any in-flight op
- in_valid  in  1  request present
- in_ready  out  1  unit idle, request accepted when in_valid&in_ready
- pc, data_Rs1, data_Rs2, imm  in  XLEN each  operand sources
- exu_opt_code  in  OPT_W  operation
- exu_sel_code  in  SEL_W  operand routing
- out_valid  out  1  exu_res valid
- out_ready  in  1  consumer takes result when out_valid&out_ready
- exu_res  out  XLEN  result, stable while out_valid&!out_ready

## Operation
- Operand select at accept: SEL_PC_ADD_4 → (pc, 4); SEL_PC_ADD_IMM → (pc, imm); SEL_RS1_ADD_IMM → (rs1, imm); SEL_RS1_ADD_RS2 → (rs1, rs2); other codes → (0, 0). Operands are latched; inputs may change after accept.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount = low log2(XLEN) bits of in2), SLT, SLTU (result 0/1 zero-extended). All results are mod 2^XLEN.
- Iterative ops: MUL (low XLEN), MULH (s×s), MULHSU (s×u), MULHU (u×u) high XLEN bits; DIV, DIVU, REM, REMU.
- Divide special cases are resolved at accept and take the single-cycle path. Divisor 0: quotient all-ones, remainder = dividend. Signed MIN/−1: quotient MIN, remainder 0.
- Undefined exu_opt_code: single-cycle path, result 0.
- FSM states:
  - IDLE: in_ready=1. On accept, go to DONE (single-cycle/special) or BUSY (iterative), with cnt=XLEN.
  - BUSY: one radix-2 step per cycle, cnt decrements; at cnt==1 the final step is done and the state goes to DONE.
  - DONE: out_valid=1. out_ready → IDLE.
- Signed mul/div: operate on magnitudes and fix the sign at the end. Remainder sign = dividend sign.
- flush: from any state go to IDLE next cycle. out_valid drops, the result is discarded, and an accept in the same cycle is ignored.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, exu_res=0, cnt=0.
- in_ready = (state==IDLE), combinational from state only. No comb path from in_valid or out_ready to in_ready.
- Single-cycle latency: accept in cycle N → out_valid in N+1.
- Iterative latency: accept in N → out_valid in N+XLEN+1 (N+33 at XLEN=32).
- Back-to-back: after the result is taken in cycle M, the next accept is possible in M+1. Maximum throughput is 1 op / 2 cycles.
- Backpressure: DONE holds indefinitely. exu_res and out_valid must not change until taken or flushed.
- flush and out_ready in the same cycle: flush wins, the result counts as dropped.

## Structure
- Shared package (defines file): XLEN default, OPT_W/SEL_W, all EXU_* opcode constants, SEL_* routing constants, FSM state encoding.
- Sub-module ysyx_23060191_mdu_iter: shift-add multiplier and restoring divider sharing one 2·XLEN accumulator, with start/done, cnt and sign fix-up. The top level holds operand mux, single-cycle ALU, FSM and handshake.

## Test plan
- ADD, SEL_PC_ADD_4, pc=0x80000000 → exu_res=0x80000004 one cycle after accept. SRA rs1=0x80000000, rs2=0x21 → 0xC0000000.
- MULH rs1=0xFFFFFFFF(−1), rs2=0x00000002 → 0xFFFFFFFF. MULHU same operands → 0x00000001. out_valid exactly 33 cycles after accept.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000 and REM → 0, both 1-cycle. DIVU 7/0 → 0xFFFFFFFF and REMU → 7.
- REM rs1=−7, rs2=2 → 0xFFFFFFFF (−1). DIV → 0xFFFFFFFD (−3).
- Hold out_ready=0 for 10 cycles after DIVU 100/7=14: exu_res stays 14 and in_ready stays 0. The next op is accepted the cycle after the take.
- flush at BUSY cycle 5 of MUL → IDLE next cycle, no out_valid. rst_n low mid-BUSY → outputs at reset values immediately.
